if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage for the ARM-style 5-stage pipeline. It is the reading side of the combinational instruction ROM.
- Owns the program counter and drives the ROM address.
- Samples the returned 32-bit instruction word.
- Loads the IF/ID pipeline register that feeds decode.
- Handles hazard freeze, taken-branch redirect, end-of-program detection and a retired-fetch counter.

## Interface
Parameters:
- RESET_PC, 32'd0, PC value after reset.
- LAST_ADDR, 32'd68, byte address of the last valid instruction in ROM.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  input  1  pipeline clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- freeze  input  1  hazard-unit stall: hold PC and IF/ID contents.
- branch_taken  input  1  from EXE: redirect PC to branch_addr and squash the fetched word.
- branch_addr  input  32  branch target byte address.
- imem_addr  output  32  current PC, driven combinationally from the PC register to the ROM.
- imem_rdata  input  32  instruction word returned combinationally by the ROM in the same cycle.
- if_id_pc  output  32  PC+4 of the instruction held in IF/ID.
- if_id_instr  output  32  instruction held in IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction; when 0, decode treats the stage as a bubble.
- prog_done  output  1  PC has passed LAST_ADDR; fetch has stopped.
- fetch_count  output  CNT_W  number of instructions loaded into IF/ID with valid=1.

## Operation
- State is held in five registers: pc, if_id_pc, if_id_instr, if_id_valid and fetch_count.
- imem_addr = pc at all times.
- Per-edge priority is rst > branch_taken > freeze > prog_done > normal.
- Normal operation (pc <= LAST_ADDR):
  - pc <= pc + 4.
  - if_id_instr <= imem_rdata.
  - if_id_pc <= pc + 4.
  - if_id_valid <= 1.
  - fetch_count increments.
- branch_taken = 1:
  - pc <= {branch_addr[31:2], 2'b00}; the low bits are forced to zero and no misalignment error is raised.
  - if_id_valid <= 1'b0 and if_id_instr <= 32'd0, squashing the wrong-path word.
  - fetch_count does not increment.
  - branch_taken overrides freeze.
- freeze = 1 with branch_taken = 0: pc, if_id_pc, if_id_instr, if_id_valid and fetch_count all hold.
- prog_done:
  - prog_done = (pc > LAST_ADDR), unsigned compare.
  - While prog_done = 1, pc holds, if_id_valid <= 0, if_id_instr <= 0 and fetch_count holds.
  - This stops fetch from sampling undefined ROM words beyond the program.
  - A later branch_taken to an address <= LAST_ADDR clears prog_done and resumes fetch.
- Arithmetic:
  - PC increment is 32-bit modulo.
  - fetch_count saturates at all-ones and does not wrap.

## Timing
- Reset values, all asynchronous: pc = RESET_PC, if_id_pc = 0, if_id_instr = 0, if_id_valid = 0, fetch_count = 0.
- prog_done after reset equals (RESET_PC > LAST_ADDR).
- Latency: the instruction at address A appears on if_id_instr one clock edge after pc = A, provided there is no freeze or branch at that edge.
- The ROM is combinational. imem_rdata must be stable before the edge at which pc = A is sampled; no wait states are supported.
- A branch costs the squashed IF/ID bubble; squashing older stages is owned elsewhere. The target instruction enters IF/ID on the second edge after branch_taken is sampled.
- freeze spanning N edges holds all state for exactly N edges. Fetch resumes on the first edge with freeze = 0.
- Reset asserted mid-operation clears all state immediately, with no clock needed. After deassertion, the first edge fetches from RESET_PC.
- Outputs if_id_* and fetch_count are registered. imem_addr and prog_done are combinational from pc.

## Test plan
- Reset then run 3 edges with ROM program loaded:
  - pc goes 0, 4, 8, 12.
  - if_id_pc goes 4, 8, 12.
  - if_id_instr equals ROM[0], ROM[4], ROM[8].
  - if_id_valid = 1 from edge 1.
  - fetch_count = 3.
- freeze = 1 for 2 edges while pc = 16:
  - pc stays 16; IF/ID keeps ROM[12]; fetch_count is unchanged.
  - After release, the next edge gives if_id_instr = ROM[16] and pc = 20.
- branch_taken = 1 with branch_addr = 32'd58 at pc = 40:
  - Next edge: pc = 56 (aligned) and if_id_valid = 0.
  - Following edge: if_id_instr = ROM[56] and if_id_pc = 60.
- branch_taken and freeze both 1, branch_addr = 8: branch wins, pc = 8 and if_id_valid = 0.
- Sequential fetch from 0 to past LAST_ADDR = 68:
  - At pc = 72, prog_done = 1 and pc holds at 72.
  - if_id_valid drops to 0 after ROM[68] is delivered.
  - fetch_count = 18.
  - Then branch to 0: prog_done = 0 and fetch resumes.
- Assert rst asynchronously mid-cycle at pc = 24 with valid = 1:
  - All outputs go immediately to their reset values and imem_addr = 0.
  - The first edge after release loads ROM[0].

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the program counter, addresses the
// combinational instruction ROM and loads the IF/ID pipeline register.
// Per-edge priority: reset, branch redirect, freeze, end-of-program, fetch.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'd0,
   parameter logic [31:0] LAST_ADDR = 32'd68,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             branch_taken,
   input  logic [31:0]      branch_addr,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      if_id_pc,
   output logic [31:0]      if_id_instr,
   output logic             if_id_valid,
   output logic             prog_done,
   output logic [CNT_W-1:0] fetch_count
);

   logic [31:0]      r_pc;
   logic [31:0]      r_ifIdPc;
   logic [31:0]      r_ifIdInstr;
   logic             r_ifIdValid;
   logic [CNT_W-1:0] r_fetchCount;

   logic [31:0]      w_pcPlus4;
   logic [31:0]      w_branchTarget;
   logic             w_progDone;
   logic [CNT_W-1:0] w_countNext;

   // Next sequential PC wraps modulo 2^32; branch targets are word-aligned
   // by dropping the low two bits rather than flagging misalignment.
   assign w_pcPlus4      = r_pc + 32'd4;
   assign w_branchTarget = {branch_addr[31:2], 2'b00};

   // Once the PC runs beyond the last instruction the ROM contents are
   // undefined, so fetch stops until a branch brings the PC back in range.
   assign w_progDone = (r_pc > LAST_ADDR);

   // The retired-fetch counter sticks at all-ones instead of wrapping.
   assign w_countNext = (r_fetchCount == {CNT_W{1'b1}}) ? r_fetchCount
                                                         : r_fetchCount + 1'b1;

   // PC and IF/ID register update, with the redirect/stall/stop priorities.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_ifIdPc     <= 32'd0;
         r_ifIdInstr  <= 32'd0;
         r_ifIdValid  <= 1'b0;
         r_fetchCount <= '0;
      end else if (branch_taken) begin
         r_pc         <= w_branchTarget;
         r_ifIdInstr  <= 32'd0;
         r_ifIdValid  <= 1'b0;
      end else if (freeze) begin
         r_pc         <= r_pc;
      end else if (w_progDone) begin
         r_ifIdInstr  <= 32'd0;
         r_ifIdValid  <= 1'b0;
      end else begin
         r_pc         <= w_pcPlus4;
         r_ifIdPc     <= w_pcPlus4;
         r_ifIdInstr  <= imem_rdata;
         r_ifIdValid  <= 1'b1;
         r_fetchCount <= w_countNext;
      end
   end

   assign imem_addr   = r_pc;
   assign prog_done   = w_progDone;
   assign if_id_pc    = r_ifIdPc;
   assign if_id_instr = r_ifIdInstr;
   assign if_id_valid = r_ifIdValid;
   assign fetch_count = r_fetchCount;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for the fetch stage: a small ROM model answers imem_addr
// combinationally, and each step checks the stage against hand-derived values.
module tb_if_fetch_stage;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        prog_done;
   logic [15:0] fetch_count;

   int compareCount  = 0;
   int mismatchCount = 0;

   if_fetch_stage #(
      .RESET_PC  (32'd0),
      .LAST_ADDR (32'd68),
      .CNT_W     (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .if_id_pc     (if_id_pc),
      .if_id_instr  (if_id_instr),
      .if_id_valid  (if_id_valid),
      .prog_done    (prog_done),
      .fetch_count  (fetch_count)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every ROM word is unique to its address so a wrong fetch is visible.
   function automatic logic [31:0] romWord(input logic [31:0] addr);
      return {16'hE3A0, 8'h5A, addr[7:0]};
   endfunction

   // Combinational ROM responding to the current PC.
   always_comb imem_rdata = romWord(imem_addr);

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compareCount++;
      assert (observed === expected)
      else begin
         mismatchCount++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic [31:0] expPc,
                             input logic [31:0] expIfPc, input logic [31:0] expInstr,
                             input logic expValid, input logic expDone,
                             input logic [15:0] expCount);
      checkOutput({tag, ".imem_addr"},   {32'd0, imem_addr},   {32'd0, expPc});
      checkOutput({tag, ".if_id_pc"},    {32'd0, if_id_pc},    {32'd0, expIfPc});
      checkOutput({tag, ".if_id_instr"}, {32'd0, if_id_instr}, {32'd0, expInstr});
      checkOutput({tag, ".if_id_valid"}, {63'd0, if_id_valid}, {63'd0, expValid});
      checkOutput({tag, ".prog_done"},   {63'd0, prog_done},   {63'd0, expDone});
      checkOutput({tag, ".fetch_count"}, {48'd0, fetch_count}, {48'd0, expCount});
   endtask

   // Drive inputs just after a falling edge, then advance through one rising
   // edge and return on the next falling edge where outputs are sampled.
   task automatic applyStimulus(input logic br, input logic [31:0] addr,
                                input logic frz);
      branch_taken = br;
      branch_addr  = addr;
      freeze       = frz;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst          = 1'b1;
      freeze       = 1'b0;
      branch_taken = 1'b0;
      branch_addr  = 32'd0;

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      checkState("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 16'd0);
      rst = 1'b0;

      // Three sequential fetches from address 0.
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkState("seq1", 32'd4, 32'd4, romWord(32'd0), 1'b1, 1'b0, 16'd1);
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkState("seq2", 32'd8, 32'd8, romWord(32'd4), 1'b1, 1'b0, 16'd2);
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkState("seq3", 32'd12, 32'd12, romWord(32'd8), 1'b1, 1'b0, 16'd3);
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkState("seq4", 32'd16, 32'd16, romWord(32'd12), 1'b1, 1'b0, 16'd4);

      // Freeze for two edges at pc = 16: everything holds.
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkState("frz1", 32'd16, 32'd16, romWord(32'd12), 1'b1, 1'b0, 16'd4);
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkState("frz2", 32'd16, 32'd16, romWord(32'd12), 1'b1, 1'b0, 16'd4);
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkState("frzRel", 32'd20, 32'd20, romWord(32'd16), 1'b1, 1'b0, 16'd5);

      // Run on to pc = 40.
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1'b0, 32'd0, 1'b0);
         checkOutput("run40.pc", {32'd0, imem_addr}, {32'd0, 32'd20 + 32'(4 * k)});
      end
      checkOutput("run40.count", {48'd0, fetch_count}, 64'd10);

      // Misaligned branch target 58 aligns to 56 and squashes IF/ID.
      applyStimulus(1'b1, 32'd58, 1'b0);
      checkState("br58", 32'd56, 32'd40, 32'd0, 1'b0, 1'b0, 16'd10);
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkState("br58tgt", 32'd60, 32'd60, romWord(32'd56), 1'b1, 1'b0, 16'd11);

      // Branch together with freeze: the branch wins.
      applyStimulus(1'b1, 32'd8, 1'b1);
      checkState("brFrz", 32'd8, 32'd60, 32'd0, 1'b0, 1'b0, 16'd11);

      // Fetch up to pc = 24 with a valid word in IF/ID.
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b0, 32'd0, 1'b0);
      end
      checkState("pre24", 32'd24, 32'd24, romWord(32'd20), 1'b1, 1'b0, 16'd15);

      // Asynchronous reset mid-cycle, no clock edge involved.
      #2 rst = 1'b1;
      #1 checkState("asyncRst", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 16'd0);
      #1 rst = 1'b0;
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkState("postRst", 32'd4, 32'd4, romWord(32'd0), 1'b1, 1'b0, 16'd1);

      // Sequential fetch through LAST_ADDR = 68.
      for (int k = 2; k <= 18; k++) begin
         applyStimulus(1'b0, 32'd0, 1'b0);
         checkOutput("walk.instr", {32'd0, if_id_instr},
                     {32'd0, romWord(32'(4 * (k - 1)))});
      end
      checkState("lastWord", 32'd72, 32'd72, romWord(32'd68), 1'b1, 1'b1, 16'd18);
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkState("done1", 32'd72, 32'd72, 32'd0, 1'b0, 1'b1, 16'd18);
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkState("done2", 32'd72, 32'd72, 32'd0, 1'b0, 1'b1, 16'd18);

      // Branch back to 0 clears prog_done and fetch resumes.
      applyStimulus(1'b1, 32'd0, 1'b0);
      checkState("resumeBr", 32'd0, 32'd72, 32'd0, 1'b0, 1'b0, 16'd18);
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkState("resume", 32'd4, 32'd4, romWord(32'd0), 1'b1, 1'b0, 16'd19);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compareCount, mismatchCount);
      $finish;
   end

endmodule
